// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arbitrating N:1 mux.
// Mode encodings and round-robin pointer arithmetic.
package arb_mux_pkg;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  // Next pointer after a grant; wraps at n, not at a power of two.
  function automatic int idx_wrap_inc(
    input int idx,
    input int n
  );
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/arb_mux_nx1_arb.sv
// Combinational round-robin / fixed-priority arbiter.
// Double-width masked search: low half holds requests at or above ptr.
module rr_arbiter #(
  parameter  int N_IN = 8,
  localparam int SELW = $clog2(N_IN)
) (
  input  logic [N_IN-1:0] req,
  input  logic [SELW-1:0] ptr,
  input  logic            rr_en,
  output logic [N_IN-1:0] grant,
  output logic [SELW-1:0] grant_idx,
  output logic            any_grant
);
  import arb_mux_pkg::*;

  logic [N_IN-1:0]   mask;
  logic [2*N_IN-1:0] dbl;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N_IN; i++) begin
      mask[i] = (rr_en == ARB_FIXED) || (i >= int'(ptr));
    end
    dbl = {req, req & mask};
  end

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    grant_idx = '0;
    any_grant = 1'b0;
    for (int i = 2 * N_IN - 1; i >= 0; i--) begin
      if (dbl[i]) begin
        any_grant = 1'b1;
        grant_idx = (i >= N_IN) ? SELW'(i - N_IN)
                                : SELW'(i);
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < N_IN; i++) begin
      grant[i] = any_grant && (grant_idx == SELW'(i));
    end
  end

endmodule

// File: rtl/arb_mux_nx1.sv
// N-input arbitrating mux with valid/ready and a registered output.
// Each accepted word is tagged with the index of its source channel.
module arb_mux_nx1 #(
  parameter  int N_IN  = 8,
  parameter  int WIDTH = 32,
  localparam int SELW  = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rr_en,
  input  logic [N_IN-1:0]       in_valid,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic [N_IN-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_sel,
  input  logic                  out_ready
);
  import arb_mux_pkg::*;

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  grant_idx;
  logic [N_IN-1:0]  grant;
  logic             any_grant;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  rr_arbiter #(.N_IN(N_IN)) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .rr_en     (rr_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign load     = !out_valid || out_ready;
  assign xfer     = load && any_grant;
  assign in_ready = grant & {N_IN{load}};

  // One-hot AND-OR select; grant is zero or one-hot.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      sel_data = sel_data
               | (in_data[i*WIDTH +: WIDTH]
                  & {WIDTH{grant[i]}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else begin
      if (load) out_valid <= any_grant;
      if (xfer) begin
        out_data <= sel_data;
        out_sel  <= grant_idx;
        if (rr_en == ARB_RR) begin
          ptr <= SELW'(idx_wrap_inc(int'(grant_idx), N_IN));
        end
      end
    end
  end

endmodule
